// File: rtl/key_debounce_if.sv
// key_debounce_if: groups the raw key pins and the conditioned key outputs.
//   key_n       : raw active-low key pins (driven by the board/bench side)
//   key_state   : debounced pressed level, 1 = pressed
//   key_press   : 1-cycle pulse on an accepted press
//   key_release : 1-cycle pulse on an accepted release
//   key_long    : 1-cycle pulse on a long press
// Modports: master = pin/consumer side, slave = the debouncer.
interface key_debounce_if #(
  parameter int KEY_N = 4
) ();
  logic [KEY_N-1:0] key_n;
  logic [KEY_N-1:0] key_state;
  logic [KEY_N-1:0] key_press;
  logic [KEY_N-1:0] key_release;
  logic [KEY_N-1:0] key_long;

  modport master (
    output key_n,
    input  key_state, key_press, key_release, key_long
  );

  modport slave (
    input  key_n,
    output key_state, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: multi-channel push-button conditioner.
// Each raw active-low key is synchronised (2 FFs), then debounced by a
// per-key 4-state FSM and counter. Produces a registered debounced level
// plus one-cycle press/release pulses, and optionally a long-press pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key_debounce_if.slave (key_n in; key_state/key_press/
//           key_release/key_long out)
// Optional feature: define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press
// counters; otherwise key_long is tied to 0.
module key_debounce #(
  parameter int KEY_N           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debounce_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_cfg_error
    $error("key_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  logic [KEY_N-1:0] sync1;
  logic [KEY_N-1:0] sync2;
  logic [KEY_N-1:0] s;
  logic [KEY_N-1:0] held_v;
  logic [KEY_N-1:0] press_v;
  logic [KEY_N-1:0] release_v;

  // Synchronisers reset to 1 so every key starts out released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  logic [KEY_N-1:0] long_v;
`endif

  for (genvar i = 0; i < KEY_N; i++) begin : g_key
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          press_nx;
    logic          release_nx;
    logic          held_q;
    logic          press_q;
    logic          release_q;

    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
        IDLE: begin
          if (s[i]) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = HELD;
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_nx = HELD;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            release_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    // key_state is registered from the next state so it moves on the same
    // edge as the matching pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        held_q    <= (state_nx == HELD) || (state_nx == RELEASE_WAIT);
        press_q   <= press_nx;
        release_q <= release_nx;
      end
    end

    assign held_v[i]    = held_q;
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_nx;
    logic          ldone;
    logic          ldone_nx;
    logic          long_nx;
    logic          long_q;

    // Counts through RELEASE_WAIT as well, so release bounces do not restart
    // it; ldone limits firing to once per press after saturation.
    always_comb begin
      lcnt_nx  = lcnt;
      ldone_nx = ldone;
      long_nx  = 1'b0;
      if (press_nx || state_nx == IDLE) begin
        lcnt_nx  = '0;
        ldone_nx = 1'b0;
      end else if (state == HELD || state == RELEASE_WAIT) begin
        if (lcnt == LONG_LAST) begin
          if (!ldone) begin
            long_nx  = 1'b1;
            ldone_nx = 1'b1;
          end
        end else begin
          lcnt_nx = lcnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lcnt   <= '0;
        ldone  <= 1'b0;
        long_q <= 1'b0;
      end else begin
        lcnt   <= lcnt_nx;
        ldone  <= ldone_nx;
        long_q <= long_nx;
      end
    end

    assign long_v[i] = long_q;
`endif
  end

  assign bus.key_state   = held_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  assign bus.key_long    = long_v;
`else
  assign bus.key_long    = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce with
// KEY_N=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=40. Inputs change and outputs are
// sampled on the falling clock edge. Cycle index c counts falling edges after
// the input change, so an accepted edge shows up at c = 11.
module tb_key_debounce;
  localparam int KEY_N = 4;
  localparam int DEB   = 8;
  localparam int LONG  = 40;
  localparam int LAT   = DEB + 3;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  key_debounce_if #(.KEY_N(KEY_N)) bus ();

  key_debounce #(
    .KEY_N(KEY_N),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.key_n = 4'hF;
    #2 rst_n  = 1'b0;
    #1;
    check("rst_state",   bus.key_state,   4'b0000);
    check("rst_press",   bus.key_press,   4'b0000);
    check("rst_release", bus.key_release, 4'b0000);
    check("rst_long",    bus.key_long,    4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single press on key 0.
    bus.key_n[0] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("t1_press", bus.key_press, (c == LAT) ? 4'b0001 : 4'b0000);
      check("t1_state", bus.key_state, (c >= LAT) ? 4'b0001 : 4'b0000);
      check("t1_rel",   bus.key_release, 4'b0000);
    end

    // Key 1 bounces with 3-cycle phases; key 0 stays held.
    for (int c = 0; c < 45; c++) begin
      bus.key_n[1] = (c < 30) ? (((c / 3) % 2) == 1) : 1'b1;
      @(negedge clk);
      check("t2_state", bus.key_state,   4'b0001);
      check("t2_press", bus.key_press,   4'b0000);
      check("t2_rel",   bus.key_release, 4'b0000);
    end

    // Key 0 release with one 4-cycle bounce back to pressed.
    bus.key_n[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_bounce_state", bus.key_state,   4'b0001);
      check("t3_bounce_rel",   bus.key_release, 4'b0000);
    end
    bus.key_n[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t3_bounce_state", bus.key_state,   4'b0001);
      check("t3_bounce_rel",   bus.key_release, 4'b0000);
    end
    bus.key_n[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("t3_rel",   bus.key_release, (c == LAT) ? 4'b0001 : 4'b0000);
      check("t3_state", bus.key_state,   (c <  LAT) ? 4'b0001 : 4'b0000);
      check("t3_press", bus.key_press,   4'b0000);
    end

    // Key 2 held 100 cycles with a short release bounce in the middle.
    bus.key_n[2] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      check("t4_press", bus.key_press, (c == LAT) ? 4'b0100 : 4'b0000);
      check("t4_state", bus.key_state, (c >= LAT) ? 4'b0100 : 4'b0000);
      check("t4_long",  bus.key_long,
            (LONG_EN && c == LAT + LONG) ? 4'b0100 : 4'b0000);
      check("t4_rel",   bus.key_release, 4'b0000);
      if (c == 20) bus.key_n[2] = 1'b1;
      if (c == 23) bus.key_n[2] = 1'b0;
    end
    bus.key_n[2] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("t4_release", bus.key_release, (c == LAT) ? 4'b0100 : 4'b0000);
      check("t4_long_after", bus.key_long, 4'b0000);
    end

    // Keys 0 and 3 pressed together.
    bus.key_n = 4'b0110;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("t5_press", bus.key_press, (c == LAT) ? 4'b1001 : 4'b0000);
      check("t5_state", bus.key_state, (c >= LAT) ? 4'b1001 : 4'b0000);
    end

    // Reset while key 2 sits in PRESS_WAIT at count 5; keys 0/3 stay held.
    bus.key_n = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t6_pre_press", bus.key_press, 4'b0000);
      check("t6_pre_state", bus.key_state, 4'b1001);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_state",   bus.key_state,   4'b0000);
    check("t6_rst_press",   bus.key_press,   4'b0000);
    check("t6_rst_release", bus.key_release, 4'b0000);
    check("t6_rst_long",    bus.key_long,    4'b0000);
    repeat (2) @(negedge clk);
    check("t6_rst_hold_state", bus.key_state, 4'b0000);
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("t6_press", bus.key_press, (c == LAT) ? 4'b1101 : 4'b0000);
      check("t6_state", bus.key_state, (c >= LAT) ? 4'b1101 : 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
